// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with optional two's-complement input.
// Results are registered and held until the next conversion completes.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  sign_mode,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t          r_state, w_state_nxt;
  logic [WIDTH-1:0] r_mag, w_mag_nxt;
  logic [BW-1:0]   r_work, w_work_nxt, w_adj, w_shifted;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_pneg, w_pneg_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [BW-1:0]   r_bcd, w_bcd_nxt;
  logic            r_neg, w_neg_nxt;
  logic [WIDTH-1:0] w_abs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_mag   <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_pneg  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mag   <= w_mag_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pneg  <= w_pneg_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_bcd   <= w_bcd_nxt;
      r_neg   <= w_neg_nxt;
    end
  end

  // Add-3 correction on every working nibble, then one-bit shift of {work, mag}
  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (r_work[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
      end
    end
    w_shifted = {w_adj[BW-2:0], r_mag[WIDTH-1]};
  end

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct magnitude
  assign w_abs = WIDTH'(~bin + WIDTH'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_mag_nxt   = r_mag;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_pneg_nxt  = r_pneg;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_bcd_nxt   = r_bcd;
    w_neg_nxt   = r_neg;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (sign_mode && bin[WIDTH-1]) begin
            w_mag_nxt  = w_abs;
            w_pneg_nxt = 1'b1;
          end else begin
            w_mag_nxt  = bin;
            w_pneg_nxt = 1'b0;
          end
          w_work_nxt  = '0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = CONV;
        end
      end
      CONV: begin
        w_work_nxt = w_shifted;
        w_mag_nxt  = {r_mag[WIDTH-2:0], 1'b0};
        w_cnt_nxt  = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_bcd_nxt   = w_shifted;
          w_neg_nxt   = r_pneg;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign neg  = r_neg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vectors, multi-cycle corner cases,
// exhaustive sweep and randomized conversions against an arithmetic reference.
module tb_bin2bcd_seq;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  bin;
  logic              sign_mode;
  logic              busy;
  logic              done;
  logic [11:0]       bcd;
  logic              neg;

  int n_checks = 0;
  int n_errors = 0;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin       (bin),
    .sign_mode (sign_mode),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  bin;
    logic        sm;
    logic [11:0] bcd;
    logic        neg;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: signed/unsigned magnitude via plain arithmetic, digits via div/mod
  function automatic logic [12:0] ref_model(input logic [7:0] b, input logic sm);
    int v;
    logic n;
    n = sm && (b >= 8'd128);
    v = n ? (256 - int'(b)) : int'(b);
    return {n, 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Called at posedge+1 with the DUT idle; returns result captured in the done cycle
  task automatic run_conv(input logic [7:0] b, input logic sm,
                          output logic [11:0] got_bcd, output logic got_neg, output int lat);
    logic [11:0] held;
    int unstable;
    held = bcd;
    unstable = 0;
    start = 1'b1; bin = b; sign_mode = sm;
    @(posedge clk); #1;
    start = 1'b0;
    bin = 8'($urandom); sign_mode = 1'($urandom);
    lat = 0;
    while (!done && lat < 30) begin
      if (!busy || bcd !== held) unstable++;
      @(posedge clk); #1;
      lat++;
    end
    got_bcd = bcd;
    got_neg = neg;
    check("busy_and_hold_during_conv", 32'(unstable), 32'd0);
    @(posedge clk); #1;
    check("done_single_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic conv_and_check(input logic [7:0] b, input logic sm);
    logic [11:0] gb;
    logic gn;
    int lat;
    logic [12:0] exp;
    int bad_nib;
    exp = ref_model(b, sm);
    run_conv(b, sm, gb, gn, lat);
    check("latency", 32'(lat), 32'(WIDTH));
    check("bcd", {20'd0, gb}, {20'd0, exp[11:0]});
    check("neg", {31'd0, gn}, {31'd0, exp[12]});
    bad_nib = 0;
    for (int d = 0; d < 3; d++) if (gb[4*d +: 4] > 4'd9) bad_nib++;
    check("nibble_range", 32'(bad_nib), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    logic [11:0] gb;
    logic gn;
    int lat;
    int n;
    int seen_done;
    logic [7:0] rb;
    logic rs;

    vecs[0] = '{8'd255, 1'b0, 12'h255, 1'b0};
    vecs[1] = '{8'hFA,  1'b1, 12'h006, 1'b1};
    vecs[2] = '{8'h80,  1'b1, 12'h128, 1'b1};
    vecs[3] = '{8'h7F,  1'b1, 12'h127, 1'b0};
    vecs[4] = '{8'h00,  1'b1, 12'h000, 1'b0};
    vecs[5] = '{8'hFF,  1'b1, 12'h001, 1'b1};
    vecs[6] = '{8'h80,  1'b0, 12'h128, 1'b0};
    vecs[7] = '{8'd1,   1'b0, 12'h001, 1'b0};

    rst = 1'b0; start = 1'b0; bin = '0; sign_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd",  {20'd0, bcd}, 32'd0);
    check("rst_neg",  {31'd0, neg}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].bin, vecs[i].sm, gb, gn, lat);
      check("vec_latency", 32'(lat), 32'(WIDTH));
      check("vec_bcd", {20'd0, gb}, {20'd0, vecs[i].bcd});
      check("vec_neg", {31'd0, gn}, {31'd0, vecs[i].neg});
    end

    // Asynchronous reset mid-cycle while outputs hold a nonzero result
    run_conv(8'hFA, 1'b1, gb, gn, lat);
    #3 rst = 1'b0;
    #1;
    check("async_rst_bcd", {20'd0, bcd}, 32'd0);
    check("async_rst_neg", {31'd0, neg}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen_done = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done || busy || bcd !== 12'h000 || neg) seen_done++;
    end
    check("idle_after_rst", 32'(seen_done), 32'd0);

    // Start during busy is ignored; start in done cycle is accepted back-to-back
    start = 1'b1; bin = 8'd123; sign_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; bin = 8'd42;
    @(posedge clk); #1;
    start = 1'b0;
    n = 3;
    while (!done && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_ignore_latency", 32'(n), 32'(WIDTH));
    check("busy_ignore_bcd", {20'd0, bcd}, 32'h123);
    start = 1'b1; bin = 8'd99;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
      end
    end while (!done && n < 30);
    check("b2b_spacing", 32'(n), 32'(WIDTH + 1));
    check("b2b_bcd", {20'd0, bcd}, 32'h099);
    @(posedge clk); #1;
    check("b2b_done_pulse", {31'd0, done}, 32'd0);

    // Reset in the middle of a conversion
    start = 1'b1; bin = 8'd200; sign_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midconv_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("midconv_no_done", 32'(seen_done), 32'd0);
    check("midconv_bcd", {20'd0, bcd}, 32'd0);
    conv_and_check(8'd0, 1'b0);

    // Exhaustive sweep in both modes
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        conv_and_check(8'(v), 1'(m));
      end
    end

    // Random operands with random idle gaps
    repeat (200) begin
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      conv_and_check(rb, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential double-dabble converter that turns the binary ALU result into packed BCD digits for the seven-segment display multiplexer directly downstream. It accepts a start request with a binary operand and optionally interprets it as two's complement. It produces magnitude digits plus a sign flag, with a one-cycle done pulse. Outputs are registered and held stable between conversions, so the display stage can sample them at any time.

Parameters:
WIDTH, 8, bit width of the binary input; legal range 4..16
DIGITS, 3, number of BCD output digits; integrator guarantees 10^DIGITS > 2^WIDTH

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  conversion request; sampled only when busy=0
bin  in  WIDTH  binary operand, captured on the accepted start edge
sign_mode  in  1  1 = treat bin as two's complement; captured with bin
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse when new bcd/neg are valid
bcd  out  4*DIGITS  packed BCD magnitude, digit 0 (ones) in [3:0]
neg  out  1  sign of the last converted value (1 = negative)

Behaviour:
- Reset: rst low asynchronously forces the following, independent of clk:
  - state=IDLE, busy=0, done=0
  - bcd=0, neg=0
  - shift register and counter cleared
- Reset mid-conversion: aborts the conversion; no done pulse; bcd/neg read 0 after release.
- FSM states: IDLE, CONV.
- IDLE:
  - On a rising edge with start=1, capture bin and sign_mode.
  - Compute magnitude:
    - If sign_mode=1 and bin[WIDTH-1]=1: mag = (~bin)+1 as unsigned WIDTH bits, so 2^(WIDTH-1) maps correctly (e.g. 0x80 -> 128); pending_neg=1.
    - Otherwise mag=bin; pending_neg=0.
  - Clear the working BCD register, set counter=0, go to CONV, busy=1 from this edge.
- CONV, each cycle:
  - Every working nibble >=5 gets +3.
  - Then {work_bcd, mag} shifts left by 1.
  - Counter increments.
- Completion:
  - On the edge where the counter reaches WIDTH (the WIDTH-th shift), bcd <= final work_bcd and neg <= pending_neg.
  - On that same edge done=1 for exactly one cycle, busy=0, state=IDLE.
  - No add-3 is applied after the final shift.
- Latency: start sampled at edge E0; done is high in the cycle following edge E0+WIDTH. busy is high during cycles E0..E0+WIDTH-1.
- Holding: start while busy=1 is ignored, with no queuing; bin/sign_mode changes during CONV have no effect.
- Back-to-back: start=1 in the cycle where done=1 (busy=0) is accepted on the next edge, giving a throughput of one conversion per WIDTH+1 cycles.
- Output stability:
  - bcd and neg change only on completion edges or reset.
  - Intermediate working values never appear on bcd.
- Negative zero cannot occur: a 0 input always yields neg=0.
- Every emitted nibble is 0..9; unused high digits read 0.

Test Plan:
- Reset: rst=0 async mid-cycle -> busy=0, done=0, bcd=12'h000, neg=0 immediately. Release, idle 5 cycles -> outputs unchanged.
- Unsigned max: sign_mode=0, bin=8'd255, start 1 cycle -> busy high 8 cycles, then done pulse 1 cycle with bcd=12'h255, neg=0.
- Signed: sign_mode=1, bin=8'hFA -> bcd=12'h006, neg=1. bin=8'h80 -> bcd=12'h128, neg=1. bin=8'h7F -> bcd=12'h127, neg=0.
- Busy and back-to-back:
  - During busy, pulse start with bin=8'd42 -> ignored; result still from the first operand.
  - Assert start=1 with bin=8'd99 in the done cycle -> second done exactly 9 cycles after the first, with bcd=12'h099.
- Reset mid-conversion: start bin=8'd200, drop rst at cycle 4 -> no done; bcd=0. A fresh start of bin=8'd0 then yields bcd=12'h000, neg=0 after 8 cycles.
- Sweep: all 256 values in both sign modes -> bcd and neg match a reference model. Every nibble is <=9, and done pulses exactly once per accepted start.
